change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Sits directly downstream of the vend output stage.
- Consumes that stage's one-cycle dispense_valid pulse and its currency_change amount.
- Pays the change out as individual coins through a req/ack handshake to the coin hopper, using a greedy highest-denomination-first policy against a per-denomination coin inventory.
- Reports completion and any unpaid shortfall; inventory is refilled through a side port.

Parameters:
- CURRENCY_WIDTH, 7, width of change amount and shortfall
- INV_WIDTH, 8, width of each per-denomination inventory counter
- DENOM0..DENOM4, 50/20/10/5/1, coin values; index 0 highest, strictly descending
- INIT_COUNT, 10, inventory of every denomination after reset
- TIMEOUT_CYCLES, 64, ack wait limit (optional feature only)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- dispense_valid  in  1  one-cycle pulse: new change request
- currency_change  in  CURRENCY_WIDTH  change amount, sampled with dispense_valid
- coin_ack  in  1  hopper accepted current coin
- refill_en  in  1  inventory refill strobe
- refill_sel  in  3  denomination index to refill (0-4)
- refill_count  in  INV_WIDTH  coins added
- coin_req  out  1  coin request to hopper
- coin_sel  out  3  denomination index of requested coin
- busy  out  1  payout in progress
- change_done  out  1  one-cycle pulse: payout finished
- change_shortfall  out  CURRENCY_WIDTH  unpaid amount of last payout, held until next done
- overrun_err  out  1  one-cycle pulse: request dropped while busy
- timeout_err  out  1  one-cycle pulse: hopper timeout (optional feature)
- inv_empty  out  5  bit i high when inventory i is 0 (combinational from counters)

Behaviour:
- Reset values:
  - coin_req, coin_sel, busy, change_done, change_shortfall, overrun_err and timeout_err are all 0.
  - Every inventory counter is INIT_COUNT.
  - State is IDLE; internal remaining register is 0.
- FSM states: IDLE, SELECT, ISSUE, DONE.
- IDLE:
  - On dispense_valid with currency_change > 0: latch remaining = currency_change and go to SELECT; busy is 1 from the next cycle.
  - On dispense_valid with currency_change == 0: go to DONE directly.
- SELECT (1 cycle):
  - Pick the lowest index i where DENOMi <= remaining and inv[i] > 0.
  - If found: register coin_sel = i, go to ISSUE.
  - If none: go to DONE.
- ISSUE:
  - coin_req = 1 and coin_sel stable until coin_ack is sampled high.
  - In the ack cycle: remaining -= DENOM[coin_sel]; inv[coin_sel] -= 1; coin_req drops the next cycle.
  - Next state is DONE if remaining == 0, otherwise SELECT.
  - coin_ack outside ISSUE is ignored.
- DONE (1 cycle):
  - change_done = 1; change_shortfall = remaining; busy = 0 on exit.
  - Return to IDLE.
- Throughput:
  - Minimum 2 cycles per coin (SELECT + ISSUE with same-cycle ack).
  - dispense_valid-to-done latency for 0 change: 2 cycles.
- Overrun: dispense_valid while not in IDLE leaves the request ignored and pulses overrun_err the next cycle; the payout in progress is unaffected.
- Refill:
  - Accepted in any state.
  - inv[refill_sel] += refill_count, saturating at 2^INV_WIDTH-1.
  - refill_sel > 4 is ignored.
  - Refill and decrement of the same counter in one cycle: new = sat(inv + refill_count - 1).
  - A refill landing during SELECT takes effect in the next selection.
- Arithmetic:
  - remaining never underflows, since selection guarantees DENOM <= remaining.
  - Shortfall equals the unpaid remainder; no partial rounding.
- Reset mid-payout: everything returns to reset values immediately, coin_req drops asynchronously, and inventory reloads INIT_COUNT.

Optional Feature:
- Macro: COIN_TIMEOUT_EN
- Defined:
  - A wait counter clears on ISSUE entry.
  - If coin_ack is not seen within TIMEOUT_CYCLES cycles of coin_req high:
    - coin_req drops and timeout_err pulses.
    - inv[coin_sel] is forced to 0 (denomination treated as jammed).
    - FSM goes to SELECT and retries with the remaining denominations.
- Not defined: ISSUE waits indefinitely; timeout_err tied 0; no wait counter.

Test Plan:
- Defaults, change 87, ack same cycle -> coin_sel sequence 0,1,2,3,4,4; change_done with shortfall 0; inv = 9,9,9,9,8.
- inv[0] = 0, change 60 -> three coins of index 1; shortfall 0; inv[1] = 7.
- Refill to zero all but inv[4] = 1, then change 3 -> one coin of index 4; change_done with shortfall 2; inv_empty = 5'b11111.
- change 0 -> change_done two cycles after dispense_valid, shortfall 0, no coin_req; second dispense_valid during a 87 payout -> overrun_err, payout still completes.
- inv[2] = 250, refill_en sel 2 count 10 during the ack of a 10 coin -> inv[2] = 255 (saturated).
- COIN_TIMEOUT_EN, withhold ack on the first 50 coin of change 70 -> timeout_err after 64 cycles; inv[0] = 0; then coins 1,1,1 (20+20+20) and 2 (10); shortfall 0.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout engine behind the vend output stage.
// Takes a change amount, pays it out one coin at a time over a req/ack
// handshake to the hopper, highest denomination first, against a
// per-denomination inventory that can be refilled at any time.
// Optional build macro: COIN_TIMEOUT_EN (hopper ack timeout, jams the coin).
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for dispense_valid
//   SELECT | one cycle: choose highest affordable denomination in stock
//   ISSUE  | coin_req high, waiting for coin_ack (or timeout)
//   DONE   | one cycle: payout finished, shortfall captured
module change_dispenser #(
    parameter int CURRENCY_WIDTH = 7,
    parameter int INV_WIDTH      = 8,
    parameter int DENOM0         = 50,
    parameter int DENOM1         = 20,
    parameter int DENOM2         = 10,
    parameter int DENOM3         = 5,
    parameter int DENOM4         = 1,
    parameter int INIT_COUNT     = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      dispense_valid,
    input  logic [CURRENCY_WIDTH-1:0] currency_change,
    input  logic                      coin_ack,
    input  logic                      refill_en,
    input  logic [2:0]                refill_sel,
    input  logic [INV_WIDTH-1:0]      refill_count,
    output logic                      coin_req,
    output logic [2:0]                coin_sel,
    output logic                      busy,
    output logic                      change_done,
    output logic [CURRENCY_WIDTH-1:0] change_shortfall,
    output logic                      overrun_err,
    output logic                      timeout_err,
    output logic [4:0]                inv_empty
);

    localparam int NUM_DENOM = 5;
    localparam logic [INV_WIDTH-1:0] INV_MAX  = '1;
    localparam logic [INV_WIDTH-1:0] INV_INIT = INV_WIDTH'(INIT_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CURRENCY_WIDTH-1:0] remaining;
    logic [CURRENCY_WIDTH-1:0] remaining_nxt;
    logic [2:0]                coin_sel_nxt;

    logic [INV_WIDTH-1:0]      inv     [NUM_DENOM];
    logic [INV_WIDTH-1:0]      inv_nxt [NUM_DENOM];
    logic [INV_WIDTH:0]        inv_sum [NUM_DENOM];

    logic                      pick_found;
    logic [2:0]                pick_idx;
    logic                      dec_en;
    logic                      jam_en;
    logic                      timeout_hit;

    // Coin value of a denomination index; out-of-range indices are worth 0.
    function automatic logic [CURRENCY_WIDTH-1:0] denom_of(input logic [2:0] idx);
        case (idx)
            3'd0:    denom_of = CURRENCY_WIDTH'(DENOM0);
            3'd1:    denom_of = CURRENCY_WIDTH'(DENOM1);
            3'd2:    denom_of = CURRENCY_WIDTH'(DENOM2);
            3'd3:    denom_of = CURRENCY_WIDTH'(DENOM3);
            3'd4:    denom_of = CURRENCY_WIDTH'(DENOM4);
            default: denom_of = '0;
        endcase
    endfunction

    // Greedy pick: lowest index (largest coin) that fits and is in stock.
    // Scanning from the small end lets the last hit win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if ((denom_of(3'(i)) <= remaining) && (inv[i] != '0)) begin
                pick_found = 1'b1;
                pick_idx   = 3'(i);
            end
        end
    end

`ifdef COIN_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Ack wait timer: loaded on the way into ISSUE, counts down while waiting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (state == SELECT) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ISSUE) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Terminal count reached in the last allowed ISSUE cycle with no ack.
    assign timeout_hit = (state == ISSUE) && !coin_ack && (wait_cnt == '0);
`else
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    // State, remaining amount and the latched coin selection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            remaining <= '0;
            coin_sel  <= 3'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            coin_sel  <= coin_sel_nxt;
        end
    end

    // Next-state logic and inventory decrement/jam strobes.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        coin_sel_nxt  = coin_sel;
        dec_en        = 1'b0;
        jam_en        = 1'b0;
        case (state)
            IDLE: begin
                if (dispense_valid) begin
                    if (currency_change != '0) begin
                        remaining_nxt = currency_change;
                        state_nxt     = SELECT;
                    end else begin
                        remaining_nxt = '0;
                        state_nxt     = DONE;
                    end
                end
            end
            SELECT: begin
                if (pick_found) begin
                    coin_sel_nxt = pick_idx;
                    state_nxt    = ISSUE;
                end else begin
                    state_nxt = DONE;
                end
            end
            ISSUE: begin
                if (coin_ack) begin
                    // Selection guaranteed the coin fits, so no underflow here.
                    remaining_nxt = remaining - denom_of(coin_sel);
                    dec_en        = 1'b1;
                    state_nxt     = (remaining_nxt == '0) ? DONE : SELECT;
                end else if (timeout_hit) begin
                    jam_en    = 1'b1;
                    state_nxt = SELECT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered status pulses and the held shortfall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            change_done      <= 1'b0;
            change_shortfall <= '0;
            overrun_err      <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            change_done <= (state == DONE);
            if (state == DONE) begin
                change_shortfall <= remaining;
            end
            overrun_err <= dispense_valid && (state != IDLE);
            timeout_err <= timeout_hit;
        end
    end

    // Inventory update: refill and payout decrement merge in one saturating sum;
    // a jammed denomination is forced empty regardless of any refill.
    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            inv_sum[i] = {1'b0, inv[i]};
            if (refill_en && (refill_sel == 3'(i))) begin
                inv_sum[i] = inv_sum[i] + {1'b0, refill_count};
            end
            if (dec_en && (coin_sel == 3'(i))) begin
                inv_sum[i] = inv_sum[i] - 1'b1;
            end
            if (jam_en && (coin_sel == 3'(i))) begin
                inv_nxt[i] = '0;
            end else if (inv_sum[i] > {1'b0, INV_MAX}) begin
                inv_nxt[i] = INV_MAX;
            end else begin
                inv_nxt[i] = inv_sum[i][INV_WIDTH-1:0];
            end
        end
    end

    // Inventory counters, reloaded to the initial stock on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                inv[i] <= INV_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                inv[i] <= inv_nxt[i];
            end
        end
    end

    // Empty flags straight from the counters.
    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            inv_empty[i] = (inv[i] == '0);
        end
    end

    assign coin_req = (state == ISSUE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed scenarios plus randomized payouts
// checked against a greedy payout model kept as plain integer arrays.
module tb_change_dispenser;

    localparam int CW = 7;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          dispense_valid = 1'b0;
    logic [CW-1:0] currency_change = '0;
    logic          coin_ack = 1'b0;
    logic          refill_en = 1'b0;
    logic [2:0]    refill_sel = '0;
    logic [IW-1:0] refill_count = '0;
    logic          coin_req;
    logic [2:0]    coin_sel;
    logic          busy;
    logic          change_done;
    logic [CW-1:0] change_shortfall;
    logic          overrun_err;
    logic          timeout_err;
    logic [4:0]    inv_empty;

    change_dispenser dut (
        .clk              (clk),
        .rstn             (rstn),
        .dispense_valid   (dispense_valid),
        .currency_change  (currency_change),
        .coin_ack         (coin_ack),
        .refill_en        (refill_en),
        .refill_sel       (refill_sel),
        .refill_count     (refill_count),
        .coin_req         (coin_req),
        .coin_sel         (coin_sel),
        .busy             (busy),
        .change_done      (change_done),
        .change_shortfall (change_shortfall),
        .overrun_err      (overrun_err),
        .timeout_err      (timeout_err),
        .inv_empty        (inv_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int denom [5] = '{50, 20, 10, 5, 1};
    int m_inv [5];
    int exp_sel [$];
    int obs_sel [$];
    int exp_short;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_inv[i] = 10;
    endtask

    // Greedy payout plan from the model inventory; consumes the planned coins.
    task automatic plan(input int change);
        int  rem;
        bit  found;
        rem = change;
        exp_sel.delete();
        do begin
            found = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (!found && denom[i] <= rem && m_inv[i] > 0) begin
                    found = 1'b1;
                    exp_sel.push_back(i);
                    m_inv[i] = m_inv[i] - 1;
                    rem = rem - denom[i];
                end
            end
        end while (found);
        exp_short = rem;
    endtask

    task automatic check_inv();
        logic [4:0] e;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("inv%0d", i), 32'(dut.inv[i]), m_inv[i]);
            e[i] = (m_inv[i] == 0);
        end
        chk("inv_empty", 32'(inv_empty), 32'(e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        dispense_valid = 1'b0;
        coin_ack = 1'b0;
        refill_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic refill(input int sel, input int cnt);
        @(negedge clk);
        refill_en = 1'b1;
        refill_sel = 3'(sel);
        refill_count = 8'(cnt);
        if (sel < 5) m_inv[sel] = sat(m_inv[sel] + cnt);
        @(negedge clk);
        refill_en = 1'b0;
    endtask

    // Plays the hopper until change_done; checks every requested coin.
    task automatic serve(input int change, input int dly_max, input int ov_cyc,
                         input int rf_sel, input bit noise);
        int cyc;
        int got;
        int wait_left;
        int req_seen;
        bit done;
        bit rf_used;
        cyc = 0; got = 0; wait_left = -1; req_seen = 0; done = 1'b0; rf_used = 1'b0;
        obs_sel.delete();
        while (!done && cyc < 3000) begin
            coin_ack = 1'b0;
            refill_en = 1'b0;
            dispense_valid = (cyc == ov_cyc);
            if (cyc == ov_cyc) currency_change = 7'($urandom_range(127, 1));
            if (ov_cyc >= 0 && cyc == ov_cyc + 1) chk("overrun_err", 32'(overrun_err), 1);
            if (cyc == 0 && change > 0) chk("busy_set", 32'(busy), 1);
            if (change_done) begin
                done = 1'b1;
                chk("shortfall", 32'(change_shortfall), exp_short);
                chk("coin_count", got, exp_sel.size());
                chk("busy_clr", 32'(busy), 0);
                if (change == 0) begin
                    chk("zero_latency", cyc, 1);
                    chk("zero_noreq", req_seen, 0);
                end
            end else if (coin_req) begin
                req_seen++;
                if (wait_left < 0) begin
                    obs_sel.push_back(int'(coin_sel));
                    wait_left = $urandom_range(dly_max, 0);
                end
                if (got < exp_sel.size()) chk("coin_sel", 32'(coin_sel), exp_sel[got]);
                else chk("extra_coin", got, exp_sel.size());
                if (wait_left == 0) begin
                    coin_ack = 1'b1;
                    if (rf_sel >= 0 && !rf_used && int'(coin_sel) == rf_sel) begin
                        refill_en = 1'b1;
                        refill_sel = 3'(rf_sel);
                        refill_count = 8'd10;
                        rf_used = 1'b1;
                        m_inv[rf_sel] = sat(m_inv[rf_sel] + 10);
                    end
                    got++;
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end else begin
                if (wait_left >= 0) begin
                    chk("req_held", 32'(coin_req), 1);
                    wait_left = -1;
                end
                if (noise) coin_ack = 1'($urandom_range(1, 0));
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        coin_ack = 1'b0;
        refill_en = 1'b0;
        dispense_valid = 1'b0;
        if (!done) chk("done_timeout", 32'(done), 1);
        @(negedge clk);
        chk("done_pulse", 32'(change_done), 0);
        check_inv();
    endtask

    task automatic pay(input int change, input int dly_max, input int ov_cyc,
                       input int rf_sel, input bit noise);
        plan(change);
        @(negedge clk);
        dispense_valid = 1'b1;
        currency_change = 7'(change);
        @(negedge clk);
        dispense_valid = 1'b0;
        serve(change, dly_max, ov_cyc, rf_sel, noise);
    endtask

    initial begin
        int k;
        bit any;
        int lit87 [6];
        lit87 = '{0, 1, 2, 3, 4, 4};

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        chk("rst_coin_req", 32'(coin_req), 0);
        chk("rst_coin_sel", 32'(coin_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(change_done), 0);
        chk("rst_shortfall", 32'(change_shortfall), 0);
        chk("rst_overrun", 32'(overrun_err), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        model_reset();
        check_inv();
        rstn = 1'b1;

        // Change 87 with same-cycle acks
        pay(87, 0, -1, -1, 1'b0);
        chk("seq87_len", obs_sel.size(), 6);
        for (int i = 0; i < 6 && i < obs_sel.size(); i++)
            chk("seq87", obs_sel[i], lit87[i]);
        chk("inv87_0", 32'(dut.inv[0]), 9);
        chk("inv87_4", 32'(dut.inv[4]), 8);

        // Drain the 50s, then 60 must come out as three 20s
        for (k = 0; k < 20 && m_inv[0] > 0; k++) pay(50, $urandom_range(3, 0), -1, -1, 1'b1);
        pay(60, 1, -1, -1, 1'b0);
        chk("seq60_len", obs_sel.size(), 3);
        for (int i = 0; i < obs_sel.size(); i++) chk("seq60", obs_sel[i], 1);

        // Empty everything, leave a single 1-coin, ask for 3
        do_reset();
        any = 1'b1;
        for (k = 0; k < 40 && any; k++) begin
            pay(127, $urandom_range(2, 0), -1, -1, 1'b0);
            any = 1'b0;
            for (int i = 0; i < 5; i++) if (m_inv[i] > 0) any = 1'b1;
        end
        refill(4, 1);
        pay(3, 0, -1, -1, 1'b0);
        chk("short3_len", obs_sel.size(), 1);
        if (obs_sel.size() > 0) chk("short3_sel", obs_sel[0], 4);
        chk("short3_val", 32'(change_shortfall), 2);
        chk("short3_empty", 32'(inv_empty), 32'h1f);

        // Zero change, then an overrun in the middle of an 87 payout
        do_reset();
        pay(0, 0, -1, -1, 1'b0);
        pay(87, 1, 3, -1, 1'b0);

        // Saturating refill landing on the ack of a 10 coin
        refill(2, 250 - m_inv[2]);
        chk("inv2_250", 32'(dut.inv[2]), 250);
        pay(10, 0, -1, 2, 1'b0);
        chk("inv2_sat", 32'(dut.inv[2]), 255);

        // Randomized payouts with interleaved refills (including bad selects)
        do_reset();
        repeat (30) begin
            if ($urandom_range(2, 0) == 0) refill($urandom_range(7, 0), $urandom_range(40, 0));
            pay($urandom_range(127, 0), $urandom_range(4, 0), -1, -1, 1'b1);
        end

        // Asynchronous reset in the middle of a payout
        do_reset();
        @(negedge clk);
        dispense_valid = 1'b1;
        currency_change = 7'd87;
        @(negedge clk);
        dispense_valid = 1'b0;
        k = 0;
        while (!coin_req && k < 20) begin @(negedge clk); k++; end
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        k = 0;
        while (!coin_req && k < 20) begin @(negedge clk); k++; end
        chk("mid_req", 32'(coin_req), 1);
        chk("mid_sel", 32'(coin_sel), 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_req", 32'(coin_req), 0);
        chk("arst_sel", 32'(coin_sel), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_inv0", 32'(dut.inv[0]), 10);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        check_inv();

`ifdef COIN_TIMEOUT_EN
        // Withhold the ack on the first 50 of change 70
        do_reset();
        @(negedge clk);
        dispense_valid = 1'b1;
        currency_change = 7'd70;
        @(negedge clk);
        dispense_valid = 1'b0;
        k = 0;
        while (!coin_req && k < 10) begin @(negedge clk); k++; end
        chk("to_sel", 32'(coin_sel), 0);
        k = 0;
        while (coin_req && k < 200) begin @(negedge clk); k++; end
        chk("to_len", k, 64);
        chk("to_err", 32'(timeout_err), 1);
        m_inv[0] = 0;
        plan(70);
        serve(70, 1, -1, -1, 1'b0);
        chk("to_seq_len", obs_sel.size(), 4);
        if (obs_sel.size() == 4) begin
            chk("to_seq0", obs_sel[0], 1);
            chk("to_seq1", obs_sel[1], 1);
            chk("to_seq2", obs_sel[2], 1);
            chk("to_seq3", obs_sel[3], 2);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
